// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH storage, sync write, async read, sync active-low reset, write-through bypass under REGISTER_FILE_BYPASS_EN
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (!reset) for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    else if (w_en) mem[w_addr] <= w_data;
`ifdef REGISTER_FILE_BYPASS_EN
  always_comb r_data = (w_en && reset && w_addr == r_addr) ? w_data : mem[r_addr];
`else
  always_comb r_data = mem[r_addr];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table vectors, directed corner sequences and random traffic against an array model
module tb_register_file;
  logic clk = 0, reset = 1, w_en = 0;
  logic [1:0] w_addr = 0, r_addr = 0;
  logic [7:0] w_data = 0, r_data;
  int total = 0, bad = 0;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .w_en(w_en), .w_addr(w_addr),
    .r_addr(r_addr), .w_data(w_data), .r_data(r_data));
  always #5 clk = ~clk;
  typedef struct {
    logic rn;
    logic we;
    logic [1:0] wa;
    logic [1:0] ra;
    logic [7:0] wd;
    logic [7:0] ex;
    string nm;
  } vec_t;
  vec_t v[8];
  logic [7:0] model [4];
  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] ex);
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, ex);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input string nm, input logic [7:0] e0, e1, e2, e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int a = 0; a < 4; a++) begin
      r_addr = 2'(a);
      #1;
      check($sformatf("%s_a%0d", nm, a), r_data, e[a]);
    end
  endtask
  task automatic apply(input vec_t x);
    reset = x.rn; w_en = x.we; w_addr = x.wa; r_addr = x.ra; w_data = x.wd;
    tick();
    w_en = 0; reset = 1;
    #1;
    check(x.nm, r_data, x.ex);
  endtask
  initial begin
    v[0] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, "reset"};
    v[1] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'hAA, 8'hAA, "wr0"};
    v[2] = '{1'b1, 1'b1, 2'd1, 2'd1, 8'hBB, 8'hBB, "wr1"};
    v[3] = '{1'b1, 1'b1, 2'd2, 2'd2, 8'hCC, 8'hCC, "wr2"};
    v[4] = '{1'b1, 1'b1, 2'd3, 2'd3, 8'hDD, 8'hDD, "wr3"};
    v[5] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'hEE, 8'hEE, "wr0_again"};
    v[6] = '{1'b1, 1'b0, 2'd1, 2'd1, 8'h55, 8'hBB, "hold_we0"};
    v[7] = '{1'b0, 1'b1, 2'd2, 2'd2, 8'hFF, 8'h00, "reset_beats_write"};
    #1;
    apply(v[0]);
    sweep("post_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 1; i < 5; i++) apply(v[i]);
    sweep("readback", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    for (int i = 5; i < 8; i++) apply(v[i]);
    sweep("after_mid_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    w_en = 1; w_addr = 3; w_data = 8'h33;
    tick();
    w_en = 1; w_addr = 3; r_addr = 3; w_data = 8'h77;
    #1;
    check("same_addr_before_edge", r_data, BYP ? 8'h77 : 8'h33);
    tick();
    w_en = 0;
    #1;
    check("same_addr_after_edge", r_data, 8'h77);
    w_en = 1; w_addr = 3; r_addr = 3; w_data = 8'h99; reset = 0;
    #1;
    check("no_bypass_in_reset", r_data, 8'h77);
    tick();
    reset = 1; w_en = 0;
    #1;
    check("reset_clears_same_addr", r_data, 8'h00);
    for (int a = 0; a < 4; a++) model[a] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 15) != 0);
      w_en = 1'($urandom);
      w_addr = 2'($urandom);
      r_addr = ($urandom_range(0, 3) == 0) ? w_addr : 2'($urandom);
      w_data = 8'($urandom);
      #1;
      check($sformatf("rand%0d", n), r_data,
            (BYP && w_en && reset && w_addr == r_addr) ? w_data : model[r_addr]);
      tick();
      if (!reset) for (int a = 0; a < 4; a++) model[a] = 8'h00;
      else if (w_en) model[w_addr] = w_data;
    end
    reset = 1; w_en = 0;
    for (int a = 0; a < 4; a++) begin
      r_addr = 2'(a);
      #1;
      check($sformatf("final_a%0d", a), r_data, model[a]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
